// File: rtl/hdmi_video_sequencer.sv
// Raster timing and TMDS lane control for an HDMI/DVI transmitter.
// Define HDMI_CONTROL_PERIOD_EN for video preamble and guard-band sequencing; plain DVI otherwise.
module hdmi_video_sequencer #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter logic        HSYNC_POL = 1'b0,
  parameter logic        VSYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       pixel_req,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start,
  output logic       de,
  output logic [1:0] ch0_c,
  output logic [1:0] ch1_c,
  output logic [1:0] ch2_c,
  output logic       guard_band
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_S = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_E = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_PRE_S  = 10'(H_TOTAL - 10);
  localparam logic [9:0] H_GRD_S  = 10'(H_TOTAL - 2);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] V_ACT_M1 = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_SYNC_S = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_E = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);

  localparam logic [1:0] CH0_IDLE = {~VSYNC_POL, ~HSYNC_POL};

  typedef enum logic [1:0] {
    ST_CTRL,
    ST_PREAMBLE,
    ST_GUARD,
    ST_ACTIVE
  } px_state_e;

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       de_q, de_d;
  logic       guard_q, guard_d;
  logic [1:0] ch0_q, ch0_d;
  logic [1:0] ch1_q, ch1_d;
  logic [1:0] ch2_q, ch2_d;

  logic       hsync, vsync;
  logic       next_active;
  px_state_e  px_state;

  assign pixel_req   = (h_cnt_q < H_ACT) & (v_cnt_q < V_ACT) & enable;
  assign frame_start = (h_cnt_q == '0) & (v_cnt_q == '0) & enable;
  assign x           = h_cnt_q;
  assign y           = v_cnt_q;

  assign hsync = ((h_cnt_q >= H_SYNC_S) && (h_cnt_q <= H_SYNC_E)) ? HSYNC_POL : ~HSYNC_POL;
  assign vsync = ((v_cnt_q >= V_SYNC_S) && (v_cnt_q <= V_SYNC_E)) ? VSYNC_POL : ~VSYNC_POL;

  // The last line of the frame precedes line 0, so it carries the control period too.
  assign next_active = (v_cnt_q == V_LAST) | (v_cnt_q < V_ACT_M1);

  always_comb begin
    px_state = ST_CTRL;
    if (pixel_req) begin
      px_state = ST_ACTIVE;
`ifdef HDMI_CONTROL_PERIOD_EN
    end else if (next_active && (h_cnt_q >= H_GRD_S)) begin
      px_state = ST_GUARD;
    end else if (next_active && (h_cnt_q >= H_PRE_S)) begin
      px_state = ST_PREAMBLE;
`endif
    end
  end

  always_comb begin
    h_cnt_d = '0;
    v_cnt_d = '0;
    de_d    = 1'b0;
    guard_d = 1'b0;
    ch0_d   = CH0_IDLE;
    ch1_d   = '0;
    ch2_d   = '0;
    if (enable) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
      end
      ch0_d = {vsync, hsync};
      unique case (px_state)
        ST_ACTIVE:   de_d    = 1'b1;
        ST_PREAMBLE: ch1_d   = 2'b01;
        ST_GUARD:    guard_d = 1'b1;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      de_q    <= 1'b0;
      guard_q <= 1'b0;
      ch0_q   <= CH0_IDLE;
      ch1_q   <= '0;
      ch2_q   <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      de_q    <= de_d;
      guard_q <= guard_d;
      ch0_q   <= ch0_d;
      ch1_q   <= ch1_d;
      ch2_q   <= ch2_d;
    end
  end

  assign de         = de_q;
  assign guard_band = guard_q;
  assign ch0_c      = ch0_q;
  assign ch1_c      = ch1_q;
  assign ch2_c      = ch2_q;

endmodule

// File: tb/tb_hdmi_video_sequencer.sv
// Directed bench for hdmi_video_sequencer on a reduced 38x15 raster.
// Expectations follow HDMI_CONTROL_PERIOD_EN the same way the design build does.
module tb_hdmi_video_sequencer;

  // Reduced raster: H 16/4/6/12 (total 38), V 8/2/2/3 (total 15).
  localparam int HT = 38;
  localparam int VT = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       pixel_req;
  logic [9:0] x;
  logic [9:0] y;
  logic       frame_start;
  logic       de;
  logic [1:0] ch0_c;
  logic [1:0] ch1_c;
  logic [1:0] ch2_c;
  logic       guard_band;

  int checks = 0;
  int errors = 0;
  int t = 0;

  hdmi_video_sequencer #(
    .H_ACTIVE (16),
    .H_FP     (4),
    .H_SYNC   (6),
    .H_BP     (12),
    .V_ACTIVE (8),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (3),
    .HSYNC_POL(1'b0),
    .VSYNC_POL(1'b0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .pixel_req  (pixel_req),
    .x          (x),
    .y          (y),
    .frame_start(frame_start),
    .de         (de),
    .ch0_c      (ch0_c),
    .ch1_c      (ch1_c),
    .ch2_c      (ch2_c),
    .guard_band (guard_band)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  // Registered outputs expected after the counters stood at (h, v).
  task automatic check_regs(input int h, input int v);
    logic act, hs, vs, na, pre, grd;
    act = (h < 16) && (v < 8);
    hs  = !((h >= 20) && (h <= 25));
    vs  = !((v >= 10) && (v <= 11));
    na  = (v == 14) || (v < 7);
    pre = na && (h >= 28) && (h <= 35);
    grd = na && (h >= 36);
`ifndef HDMI_CONTROL_PERIOD_EN
    pre = 1'b0;
    grd = 1'b0;
`endif
    chk("de", de, act);
    chk("guard_band", guard_band, grd);
    chk("ch0_c", ch0_c, {vs, hs});
    chk("ch1_c", ch1_c, pre ? 2'b01 : 2'b00);
    chk("ch2_c", ch2_c, 2'b00);
  endtask

  task automatic check_counters();
    int h, v;
    h = t % HT;
    v = (t / HT) % VT;
    chk("x", x, h);
    chk("y", y, v);
    chk("pixel_req", pixel_req, (h < 16) && (v < 8));
    chk("frame_start", frame_start, (h == 0) && (v == 0));
  endtask

  task automatic check_idle_regs();
    chk("idle_x", x, 0);
    chk("idle_y", y, 0);
    chk("idle_de", de, 0);
    chk("idle_guard", guard_band, 0);
    chk("idle_ch0", ch0_c, 2'b11);
    chk("idle_ch1", ch1_c, 2'b00);
    chk("idle_ch2", ch2_c, 2'b00);
  endtask

  task automatic run(input int n);
    int ph, pv;
    repeat (n) begin
      @(posedge clk);
      ph = t % HT;
      pv = (t / HT) % VT;
      t++;
      @(negedge clk);
      check_counters();
      check_regs(ph, pv);
    end
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_regs();
    chk("idle_pixel_req", pixel_req, 0);
    chk("idle_frame_start", frame_start, 0);

    reset = 1'b0;
    @(negedge clk);
    check_idle_regs();
    chk("disabled_pixel_req", pixel_req, 0);

    // First enabled cycle: frame_start and pixel_req straight away, de one edge later.
    enable = 1'b1;
    #1;
    t = 0;
    check_counters();
    chk("first_de", de, 0);
    run(600);

    // Walk to h=10, v=3 of the second frame, then drop enable.
    run(94);
    chk("drop_x", x, 10);
    chk("drop_y", y, 3);
    enable = 1'b0;
    #1;
    chk("drop_pixel_req", pixel_req, 0);
    chk("drop_frame_start", frame_start, 0);
    @(posedge clk);
    @(negedge clk);
    check_idle_regs();
    @(negedge clk);
    check_idle_regs();

    enable = 1'b1;
    #1;
    chk("reen_frame_start", frame_start, 1);
    chk("reen_pixel_req", pixel_req, 1);
    t = 0;
    run(119);
    chk("pre_reset_de", de, 1);

    // Asynchronous reset between edges during active video.
    #2 reset = 1'b1;
    #1;
    check_idle_regs();
    #1 reset = 1'b0;
    t = 0;
    run(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdmi_video_sequencer.md
Name: hdmi_video_sequencer

Overview:
- Generates raster timing and per-channel control for the three TMDS encoder lanes: DE, C1/C0 per lane, and guard-band select.
- Issues pixel requests with x/y coordinates to the frame source one cycle ahead of DE, so data with 1-cycle read latency lands aligned with DE.
- Sequences HDMI control periods: video preamble and video guard band before each active line.
- Sits between the frame source and the three encoder instances plus the downstream guard-band mux.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch; must be >= 10
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync lines
- V_BP, 33, vertical back porch
- HSYNC_POL, 0, hsync active level
- VSYNC_POL, 0, vsync active level

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run; low returns the block to its reset state synchronously
- pixel_req  out  1  combinational; counters are in the active region
- x  out  10  h_cnt (current counter value)
- y  out  10  v_cnt
- frame_start  out  1  combinational; h_cnt==0 and v_cnt==0 and enable
- de  out  1  registered data enable to all lanes
- ch0_c  out  2  {C1,C0} lane 0 = {vsync,hsync}
- ch1_c  out  2  {CTL1,CTL0}
- ch2_c  out  2  {CTL3,CTL2}
- guard_band  out  1  registered; downstream mux substitutes guard symbols (lanes 0/2: 1011001100, lane 1: 0100110011)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- h_cnt counts 0..H_TOTAL-1 and wraps to 0. v_cnt increments when h_cnt wraps and itself wraps at V_TOTAL-1. Both are 10 bits.
- Horizontal regions (h_cnt): active 0..H_ACTIVE-1; FP next; sync H_ACTIVE+H_FP .. +H_SYNC-1; BP last. Vertical regions (v_cnt) follow the same layout.
- pixel_req = (h_cnt < H_ACTIVE) & (v_cnt < V_ACTIVE) & enable.
- Registered outputs (de, ch*_c, guard_band) reflect the counter decode of the previous cycle. Latency is exactly 1 cycle after pixel_req, x and y.
- hsync = HSYNC_POL while h_cnt is in the sync region, else ~HSYNC_POL. vsync uses VSYNC_POL over the v_cnt sync region, independent of h_cnt.
- next_active = (v_cnt == V_TOTAL-1) | (v_cnt < V_ACTIVE-1).
- Per-pixel state is decoded from counters, not stored:
  - ACTIVE: pixel_req.
  - PREAMBLE: h_cnt in H_TOTAL-10..H_TOTAL-3 & next_active.
  - GUARD: h_cnt in H_TOTAL-2..H_TOTAL-1 & next_active.
  - CTRL: otherwise.
- Outputs by state:
  - CTRL: de=0, guard_band=0, ch1_c=00, ch2_c=00.
  - PREAMBLE: de=0, guard_band=0, ch1_c=01 (CTL0=1), ch2_c=00.
  - GUARD: de=0, guard_band=1, ch1_c=00, ch2_c=00.
  - ACTIVE: de=1, guard_band=0, ch1_c=00, ch2_c=00.
- ch0_c always carries sync, including during preamble and guard.
- No preamble or guard on any vertical-blanking line. The line before v_cnt=0 (v_cnt=V_TOTAL-1) does get them.
- Reset / enable low:
  - h_cnt=0, v_cnt=0.
  - de=0, guard_band=0, ch1_c=ch2_c=00.
  - ch0_c = {~VSYNC_POL, ~HSYNC_POL}.
  - pixel_req=0, frame_start=0.
- Raising enable starts the frame: frame_start=1 and pixel_req=1 on the first enabled cycle. Dropping enable mid-line returns to the reset state on the next edge, with no partial-line completion.
- Reset asserted mid-line forces the same values immediately (asynchronous).

Optional Feature:
- Macro: HDMI_CONTROL_PERIOD_EN.
- Defined: preamble and guard sequencing as specified above.
- Undefined (plain DVI): PREAMBLE and GUARD decode to CTRL; guard_band is tied 0; ch1_c and ch2_c are tied 00. Timing and DE are unchanged.

Test Plan:
- Reset, then enable=1 with defaults. Required: frame_start=1 at the first cycle; de=1 the next cycle; de high for 640 consecutive cycles, low for 160; period 800.
- hsync, HSYNC_POL=0. Required: ch0_c[0]=0 for registered h_cnt 656..751 (96 cycles); ch0_c[1]=0 only across v_cnt 490..491 (1600 cycles).
- Preamble on v_cnt=5. Required: ch1_c=01 for 8 cycles after h_cnt 790..797, then guard_band=1 for 2 cycles, then de=1. On v_cnt=479→480 and 500: no preamble and no guard; v_cnt=524: both present.
- Drop enable at h_cnt=300, v_cnt=100. Required: next cycle x=0, y=0, de=0, sync inactive. Re-enable: frame_start=1 immediately.
- Async reset pulse between edges during active video. Required: de=0 and guard_band=0 before the next clk edge.
- Build without HDMI_CONTROL_PERIOD_EN. Required: guard_band=0, ch1_c=ch2_c=00 over a full frame; DE/sync identical to the first scenario.
